// File: rtl/video_frame_sync.sv
// video_frame_sync: start-of-frame aligner and geometry checker for a 24-bit AXI4-Stream video path.
// Beats are discarded until the first tuser. After that, frame-aligned video is forwarded through
// a 2-entry registered skid buffer. Line lengths and frame heights are measured against the
// configured geometry.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   s_axis_video_*              upstream stream (tready is registered)
//   m_axis_video_*              downstream stream (all outputs registered)
//   locked                      1 while aligned (PASS state)
//   frame_cnt                   completed, correctly sized frames (wraps)
//   line_err_cnt                lines whose length differs from H_ACTIVE (saturates)
//   frame_err_cnt               frame-structure errors (saturates)
//   last_width, last_height     measured geometry of the most recent line / frame
module video_frame_sync #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              s_axis_video_tready,
  input  logic [DATA_W-1:0] s_axis_video_tdata,
  input  logic              s_axis_video_tvalid,
  input  logic              s_axis_video_tuser,
  input  logic              s_axis_video_tlast,
  input  logic              m_axis_video_tready,
  output logic [DATA_W-1:0] m_axis_video_tdata,
  output logic              m_axis_video_tvalid,
  output logic              m_axis_video_tuser,
  output logic              m_axis_video_tlast,
  output logic              locked,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  line_err_cnt,
  output logic [CNT_W-1:0]  frame_err_cnt,
  output logic [CNT_W-1:0]  last_width,
  output logic [CNT_W-1:0]  last_height
);

  localparam logic [CNT_W-1:0] HAct   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VAct   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [0:0] {StSync, StPass} state_e;

  state_e             state_q;
  logic               locked_q;
  logic [CNT_W-1:0]   px_q, ln_q;
  logic [CNT_W-1:0]   frame_cnt_q, line_err_q, frame_err_q, last_width_q, last_height_q;

  // Skid buffer: entry 0 drives m_axis directly, entry 1 holds the overflow beat.
  logic [1:0]         count_q, count_d;
  logic               s_ready_q;
  logic [DATA_W-1:0]  e0_data_q, e1_data_q;
  logic               e0_user_q, e1_user_q, e0_last_q, e1_last_q;

  logic               in_acc, out_acc, sof, fwd, drop_err, early_sof;
  logic [CNT_W-1:0]   px_base, ln_base, px_inc, ln_inc;

  assign in_acc  = s_axis_video_tvalid && s_ready_q;
  assign out_acc = (count_q != 2'd0) && m_axis_video_tready;

  always_comb begin
    sof       = in_acc && s_axis_video_tuser;
    // In SYNC only a tuser beat passes; in PASS everything passes unless the frame is complete
    // and the beat is not a new SOF.
    fwd       = in_acc && (s_axis_video_tuser || (state_q == StPass && ln_q != VAct));
    drop_err  = in_acc && (state_q == StPass) && !s_axis_video_tuser && (ln_q == VAct);
    early_sof = sof && (state_q == StPass) && (px_q != '0 || ln_q != VAct);
    // SOF restarts counting before the beat's own EOL handling is applied.
    px_base   = sof ? '0 : px_q;
    ln_base   = sof ? '0 : ln_q;
    px_inc    = (px_base == CntMax) ? CntMax : px_base + 1'b1;
    ln_inc    = (ln_base == CntMax) ? CntMax : ln_base + 1'b1;
    count_d   = count_q + {1'b0, fwd} - {1'b0, out_acc};
  end

  // Alignment FSM with geometry counters and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StSync;
      locked_q      <= 1'b0;
      px_q          <= '0;
      ln_q          <= '0;
      frame_cnt_q   <= '0;
      line_err_q    <= '0;
      frame_err_q   <= '0;
      last_width_q  <= '0;
      last_height_q <= '0;
    end else if (drop_err) begin
      state_q  <= StSync;
      locked_q <= 1'b0;
      if (frame_err_q != CntMax) frame_err_q <= frame_err_q + 1'b1;
    end else if (fwd) begin
      state_q  <= StPass;
      locked_q <= 1'b1;
      if (sof && state_q == StPass) last_height_q <= ln_q;
      if (early_sof && frame_err_q != CntMax) frame_err_q <= frame_err_q + 1'b1;
      if (s_axis_video_tlast) begin
        last_width_q <= px_inc;
        if (px_inc != HAct && line_err_q != CntMax) line_err_q <= line_err_q + 1'b1;
        px_q <= '0;
        ln_q <= ln_inc;
        if (ln_inc == VAct) frame_cnt_q <= frame_cnt_q + 1'b1;
      end else begin
        px_q <= px_inc;
        ln_q <= ln_base;
      end
    end
  end

  // Skid buffer. A push while full cannot happen because tready is low whenever count_q == 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= 2'd0;
      s_ready_q <= 1'b0;
      e0_data_q <= '0;
      e0_user_q <= 1'b0;
      e0_last_q <= 1'b0;
      e1_data_q <= '0;
      e1_user_q <= 1'b0;
      e1_last_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      s_ready_q <= (count_d < 2'd2);
      unique case (count_q)
        2'd0: begin
          if (fwd) begin
            e0_data_q <= s_axis_video_tdata;
            e0_user_q <= s_axis_video_tuser;
            e0_last_q <= s_axis_video_tlast;
          end
        end
        2'd1: begin
          if (fwd && out_acc) begin
            e0_data_q <= s_axis_video_tdata;
            e0_user_q <= s_axis_video_tuser;
            e0_last_q <= s_axis_video_tlast;
          end else if (fwd) begin
            e1_data_q <= s_axis_video_tdata;
            e1_user_q <= s_axis_video_tuser;
            e1_last_q <= s_axis_video_tlast;
          end
        end
        default: begin
          if (out_acc) begin
            e0_data_q <= e1_data_q;
            e0_user_q <= e1_user_q;
            e0_last_q <= e1_last_q;
          end
        end
      endcase
    end
  end

  assign s_axis_video_tready = s_ready_q;
  assign m_axis_video_tvalid = (count_q != 2'd0);
  assign m_axis_video_tdata  = e0_data_q;
  assign m_axis_video_tuser  = e0_user_q;
  assign m_axis_video_tlast  = e0_last_q;
  assign locked              = locked_q;
  assign frame_cnt           = frame_cnt_q;
  assign line_err_cnt        = line_err_q;
  assign frame_err_cnt       = frame_err_q;
  assign last_width          = last_width_q;
  assign last_height         = last_height_q;

endmodule

// File: tb/tb_video_frame_sync.sv
// Directed bench for video_frame_sync using a reduced 8x4 geometry.
module tb_video_frame_sync;

  localparam int unsigned DW = 24;
  localparam int unsigned HA = 8;
  localparam int unsigned VA = 4;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0, s_user = 1'b0, s_last = 1'b0;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_valid, m_user, m_last, locked;
  logic [CW-1:0] frame_cnt, line_err_cnt, frame_err_cnt, last_width, last_height;

  logic          m_ready_dir = 1'b1;
  logic          rand_mode = 1'b0;
  logic          rand_bit = 1'b1;
  logic          exp_fwd = 1'b0;
  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] seq = 24'h100;
  logic [25:0]   exp_q[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  assign m_ready = rand_mode ? rand_bit : m_ready_dir;

  always #5 clk = ~clk;

  video_frame_sync #(
    .DATA_W  (DW),
    .H_ACTIVE(HA),
    .V_ACTIVE(VA),
    .CNT_W   (CW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .s_axis_video_tready(s_ready),
    .s_axis_video_tdata (s_data),
    .s_axis_video_tvalid(s_valid),
    .s_axis_video_tuser (s_user),
    .s_axis_video_tlast (s_last),
    .m_axis_video_tready(m_ready),
    .m_axis_video_tdata (m_data),
    .m_axis_video_tvalid(m_valid),
    .m_axis_video_tuser (m_user),
    .m_axis_video_tlast (m_last),
    .locked             (locked),
    .frame_cnt          (frame_cnt),
    .line_err_cnt       (line_err_cnt),
    .frame_err_cnt      (frame_err_cnt),
    .last_width         (last_width),
    .last_height        (last_height)
  );

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  // 25% downstream ready duty cycle when enabled.
  always @(posedge clk) begin
    #1 rand_bit = ($urandom_range(0, 3) == 0);
  end

  // Scoreboard: beats expected downstream, in order; its depth equals the DUT occupancy.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("s_ready_when_full", 32'(s_ready && exp_q.size() >= 2), 32'd0);
      chk("m_valid_occupancy", 32'(m_valid), 32'(exp_q.size() != 0));
      if (prev_stall) chk("stall_stable", 32'({m_valid, m_data}), 32'({1'b1, prev_data}));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 32'(m_data), 32'hdead);
        else begin
          chk("out_beat", 32'({m_user, m_last, m_data}), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
      if (s_valid && s_ready && exp_fwd) exp_q.push_back({s_user, s_last, s_data});
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic beat(input logic u, input logic l, input logic f);
    int   n;
    logic acc;
    s_data = seq; s_user = u; s_last = l; s_valid = 1'b1; exp_fwd = f; n = 0;
    seq = seq + 1'b1;
    do begin
      acc = s_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 300);
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
    s_valid = 1'b0;
  endtask

  task automatic send_line(input int len, input logic sof, input logic f);
    for (int i = 0; i < len; i++) beat(sof && i == 0, i == len - 1, f);
  endtask

  task automatic send_frame();
    send_line(HA, 1'b1, 1'b1);
    for (int i = 1; i < VA; i++) send_line(HA, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic chk_status(input string tag, input logic [15:0] fc, input logic [15:0] le,
                            input logic [15:0] fe, input logic lk);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(fc));
    chk({tag, "_line_err"}, 32'(line_err_cnt), 32'(le));
    chk({tag, "_frame_err"}, 32'(frame_err_cnt), 32'(fe));
    chk({tag, "_locked"}, 32'(locked), 32'(lk));
  endtask

  initial begin
    // Reset state
    idle(3);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk_status("rst", 16'd0, 16'd0, 16'd0, 1'b0);
    chk("rst_width", 32'(last_width), 32'd0);
    rst = 1'b0;
    #1 chk("release_s_ready_low", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    chk("release_s_ready_high", 32'(s_ready), 32'd1);

    // Three aligned frames, then the fourth SOF
    beat(1'b1, 1'b0, 1'b1);
    chk("first_sof_m_valid", 32'(m_valid), 32'd1);
    chk("first_sof_m_user", 32'(m_user), 32'd1);
    chk("first_sof_locked", 32'(locked), 32'd1);
    send_line(HA - 1, 1'b0, 1'b1);
    for (int i = 1; i < VA; i++) send_line(HA, 1'b0, 1'b1);
    chk("frame1_cnt", 32'(frame_cnt), 32'd1);
    send_frame();
    send_frame();
    beat(1'b1, 1'b0, 1'b1);
    chk_status("sof4", 16'd3, 16'd0, 16'd0, 1'b1);
    chk("sof4_width", 32'(last_width), 32'(HA));
    chk("sof4_height", 32'(last_height), 32'(VA));
    send_line(HA - 1, 1'b0, 1'b1);
    for (int i = 1; i < VA; i++) send_line(HA, 1'b0, 1'b1);
    chk("frame4_cnt", 32'(frame_cnt), 32'd4);
    idle(3);

    // Reset, then 100 beats without SOF are swallowed
    rst = 1'b1;
    #1 chk_status("rst2", 16'd0, 16'd0, 16'd0, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 100; i++) beat(1'b0, (i % HA) == HA - 1, 1'b0);
    idle(2);
    chk("nosof_m_valid", 32'(m_valid), 32'd0);
    chk_status("nosof", 16'd0, 16'd0, 16'd0, 1'b0);
    beat(1'b1, 1'b0, 1'b1);
    chk("b_first_user", 32'({m_valid, m_user}), 32'b11);
    send_line(HA - 1, 1'b0, 1'b1);
    for (int i = 1; i < VA; i++) send_line(HA, 1'b0, 1'b1);
    chk_status("b_frame", 16'd1, 16'd0, 16'd0, 1'b1);

    // Short line followed by a long line
    send_line(HA, 1'b1, 1'b1);
    send_line(HA - 1, 1'b0, 1'b1);
    chk("short_line_err", 32'(line_err_cnt), 32'd1);
    chk("short_width", 32'(last_width), 32'(HA - 1));
    send_line(HA + 1, 1'b0, 1'b1);
    chk("long_line_err", 32'(line_err_cnt), 32'd2);
    chk("long_width", 32'(last_width), 32'(HA + 1));
    send_line(HA, 1'b0, 1'b1);
    chk_status("c_frame", 16'd2, 16'd2, 16'd0, 1'b1);

    // Early SOF after 2 lines, then an over-tall frame
    send_line(HA, 1'b1, 1'b1);
    send_line(HA, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b1);
    chk("early_sof_err", 32'(frame_err_cnt), 32'd1);
    chk("early_sof_height", 32'(last_height), 32'd2);
    send_line(HA - 1, 1'b0, 1'b1);
    for (int i = 1; i < VA; i++) send_line(HA, 1'b0, 1'b1);
    chk_status("d_frame", 16'd3, 16'd2, 16'd1, 1'b1);
    send_line(HA, 1'b0, 1'b0);
    chk_status("tall", 16'd3, 16'd2, 16'd2, 1'b0);
    send_frame();
    chk_status("d_resync", 16'd4, 16'd2, 16'd2, 1'b1);

    // Random downstream back-pressure
    rand_mode = 1'b1;
    send_frame();
    send_frame();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) idle(1);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    rand_mode = 1'b0;
    chk_status("e_frames", 16'd6, 16'd2, 16'd2, 1'b1);

    // Fill the skid buffer, then reset mid-line
    m_ready_dir = 1'b0;
    s_data = seq; s_user = 1'b1; s_last = 1'b0; s_valid = 1'b1; exp_fwd = 1'b1;
    @(posedge clk); #1;
    s_data = seq + 1'b1; s_user = 1'b0;
    @(posedge clk); #1;
    chk("full_s_ready", 32'(s_ready), 32'd0);
    chk("full_m_valid", 32'(m_valid), 32'd1);
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_m_data", 32'(m_data), 32'd0);
    chk("midrst_s_ready", 32'(s_ready), 32'd0);
    chk_status("midrst", 16'd0, 16'd0, 16'd0, 1'b0);
    chk("midrst_dims", 32'({last_width, last_height}), 32'd0);
    idle(2);
    rst = 1'b0;
    m_ready_dir = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) beat(1'b0, 1'b0, 1'b0);
    idle(2);
    chk("post_rst_m_valid", 32'(m_valid), 32'd0);
    beat(1'b1, 1'b0, 1'b1);
    chk("post_rst_first_user", 32'({m_valid, m_user}), 32'b11);
    send_line(HA - 1, 1'b0, 1'b1);
    for (int i = 1; i < VA; i++) send_line(HA, 1'b0, 1'b1);
    chk_status("f_frame", 16'd1, 16'd0, 16'd0, 1'b1);
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_frame_sync.md
Name: video_frame_sync

Overview:
- Sits directly downstream of the 32-to-24-bit video repacker, on the 24-bit RGB AXI4-Stream video path, ahead of the frame buffer writer.
- Discards beats until the first start-of-frame (tuser) and forwards only frame-aligned video.
- Checks every line length and frame height against the configured geometry, and publishes measured geometry and saturating error counters for debug.
- The output is fully registered through a 2-entry skid buffer, so no combinational path exists from m_axis_video_tready to s_axis_video_tready.

Parameters:
- DATA_W, 24, pixel width in bits.
- H_ACTIVE, 640, expected beats per line (tlast on beat H_ACTIVE-1).
- V_ACTIVE, 480, expected lines per frame.
- CNT_W, 16, width of the pixel, line and status counters.

Ports:
- clk  in  1  video clock.
- rst  in  1  asynchronous active-high reset.
- s_axis_video_tready  out  1  upstream ready; registered.
- s_axis_video_tdata  in  DATA_W  pixel.
- s_axis_video_tvalid  in  1  upstream valid.
- s_axis_video_tuser  in  1  start of frame.
- s_axis_video_tlast  in  1  end of line.
- m_axis_video_tready  in  1  downstream ready.
- m_axis_video_tdata  out  DATA_W  pixel.
- m_axis_video_tvalid  out  1  downstream valid.
- m_axis_video_tuser  out  1  start of frame.
- m_axis_video_tlast  out  1  end of line.
- locked  out  1  1 while in PASS state.
- frame_cnt  out  CNT_W  completed, correctly sized frames; wraps.
- line_err_cnt  out  CNT_W  lines whose length differs from H_ACTIVE; saturates.
- frame_err_cnt  out  CNT_W  frame-structure errors; saturates.
- last_width  out  CNT_W  beat count of the most recent line.
- last_height  out  CNT_W  line count of the most recent frame.

Behaviour:
- Reset (async, active-high, takes effect immediately and at any point mid-operation):
  - Skid buffer emptied; m_axis_video_tvalid=0, tuser=0, tlast=0, tdata=0.
  - s_axis_video_tready=0 while rst is high, then 1 on the first clk edge after release.
  - All counters and status outputs are 0; FSM enters SYNC; locked=0.
- Accept: an input beat is taken when s_axis_video_tvalid && s_axis_video_tready. An output beat is taken when m_axis_video_tvalid && m_axis_video_tready.
- Skid buffer:
  - 2 entries. s_axis_video_tready is a register equal to "fewer than 2 entries after this cycle".
  - Accepted PASS beats appear on m_axis one cycle later when the buffer was empty.
  - Output order is preserved. m_axis_video_tvalid and m_axis_video_tdata are stable while stalled.
  - Sustains 1 beat/clk when m_axis_video_tready is held high.
- FSM states: SYNC, PASS.
  - SYNC:
    - Accepted beats with tuser=0 are dropped: consumed, not forwarded, no counter update.
    - A beat with tuser=1 moves the FSM to PASS, is forwarded, and starts counting with px=0, ln=0.
  - PASS:
    - Every accepted beat is forwarded; px increments, saturating at all-ones.
    - On tlast: last_width <= px+1; if px+1 != H_ACTIVE then line_err_cnt++; px <= 0; ln++.
    - When tlast completes line V_ACTIVE-1: frame_cnt++, and the FSM waits for the next SOF with ln held at V_ACTIVE.
    - A tuser beat while px!=0 or ln!=V_ACTIVE (early SOF or short frame): frame_err_cnt++. The beat is forwarded, and counting restarts at px=0, ln=0.
    - On any tuser beat in PASS: last_height <= ln.
    - A beat without tuser while ln==V_ACTIVE (frame too tall or missing SOF): frame_err_cnt++, the beat is dropped, and the FSM moves to SYNC.
- Simultaneous tuser and tlast on one beat: SOF handling is applied first, then EOL handling, giving a line length of 1.
- Status update timing:
  - Counters, last_width and last_height update on the clk edge that accepts the beat.
  - locked changes on the same edge as the FSM state.
- Saturating counters stick at all-ones. frame_cnt wraps to 0.
- Downstream stall never drops data: upstream is back-pressured through the registered tready.

Test Plan:
- Reset, then 3 frames of 480 lines × 640 beats with tuser on the first beat, m_ready=1 → output is bit-identical to input with 1-cycle latency; frame_cnt=3, line_err_cnt=0, frame_err_cnt=0, last_width=640, last_height=480 after the 4th SOF; locked=1 from the first SOF.
- 100 beats with no tuser, then a normal frame → the 100 beats are accepted (tready=1) but never appear on m_axis; the first output beat carries tuser=1.
- Line 5 of a frame ends after 639 beats and line 6 after 641 beats → line_err_cnt=2, last_width=641 after line 6, frame_cnt still increments at frame end.
- SOF arrives after 200 lines → frame_err_cnt=1, last_height=200, the new frame is forwarded and counted from line 0; a 481st line without SOF → frame_err_cnt=2, locked=0, dropping until the next tuser.
- Random m_ready duty cycle (25%) with continuous input → no beat lost or duplicated, s_ready never asserted with 2 entries held, m_tdata stable while m_valid && !m_ready.
- rst pulsed mid-line with the skid buffer full → m_valid=0 immediately, all counters 0, locked=0; post-reset data is dropped until the next tuser.
